// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_pkg
// Brief    : Shared constants and forward-select width helper for the hazard unit.
// Revision : 1.0
// ============================================================================
package hazard_pkg;

    localparam int c_REG_W_DEFAULT = 5;
    localparam int c_N_FWD_DEFAULT = 3;
    localparam int FWD_NONE        = 0;

    // One code per forwarding stage plus the "no forward" code.
    function automatic int fwd_sel_w(input int n_fwd);
        return $clog2(n_fwd + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Brief    : Busy vector, outstanding-op tracking and timeout for the multicycle unit.
// Revision : 1.0
// ============================================================================
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_W  = c_REG_W_DEFAULT,
    parameter int MC_TMO = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_mc_start,
    input  logic [REG_W-1:0]    i_mc_dst,
    input  logic                i_mc_done,
    input  logic                i_flush,
    output logic [2**REG_W-1:0] o_busy_vec,
    output logic                o_mc_busy,
    output logic                o_mc_err
);

    localparam int                 c_TMO_W   = $clog2(MC_TMO + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_MAX = c_TMO_W'(MC_TMO);

    logic [2**REG_W-1:0] r_busy;
    logic [2**REG_W-1:0] w_busy_nxt;
    logic [REG_W-1:0]    r_mc_dst;
    logic                r_mc_busy;
    logic                r_mc_err;
    logic [c_TMO_W-1:0]  r_tmo_cnt;
    logic                w_accept;
    logic                w_done;
    logic                w_tmo_hit;

    assign w_accept  = i_mc_start & ~i_flush;
    assign w_done    = i_mc_done & r_mc_busy;
    assign w_tmo_hit = r_mc_busy & ~w_done & ~w_accept & (r_tmo_cnt == c_TMO_MAX - 1'b1);

    // Clear of the retiring op is applied before the set, so a same-register
    // retire/issue leaves the bit set.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_done) begin
            w_busy_nxt[r_mc_dst] = 1'b0;
        end
        if (w_accept && (i_mc_dst != '0)) begin
            w_busy_nxt[i_mc_dst] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy    <= '0;
            r_mc_dst  <= '0;
            r_mc_busy <= 1'b0;
            r_mc_err  <= 1'b0;
            r_tmo_cnt <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            if (w_accept) begin
                r_mc_busy <= 1'b1;
                r_mc_dst  <= i_mc_dst;
            end else if (w_done) begin
                r_mc_busy <= 1'b0;
            end
            if (w_accept || w_done || !r_mc_busy) begin
                r_tmo_cnt <= '0;
            end else if (r_tmo_cnt != c_TMO_MAX) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
            if (w_tmo_hit) begin
                r_mc_err <= 1'b1;
            end
        end
    end

    assign o_busy_vec = r_busy;
    assign o_mc_busy  = r_mc_busy;
    assign o_mc_err   = r_mc_err;

endmodule
`default_nettype wire

// File: rtl/hazard_unit_ms.sv
`default_nettype none
// ============================================================================
// Module   : hazard_unit_ms
// Brief    : Forwarding select and stall generation with a multicycle scoreboard.
//            Define HZRD_PERF_CNT_EN to add the STALL_CNT counter and CNT_CLR.
// Revision : 1.0
// ============================================================================
module hazard_unit_ms
    import hazard_pkg::*;
#(
    parameter int REG_W  = c_REG_W_DEFAULT,
    parameter int N_FWD  = c_N_FWD_DEFAULT,
    parameter int MC_TMO = 64
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    input  logic [REG_W-1:0]              RS_D,
    input  logic [REG_W-1:0]              RT_D,
    input  logic [REG_W-1:0]              RS_E,
    input  logic [REG_W-1:0]              RT_E,
    input  logic                          LOAD_E,
    input  logic                          MC_D,
    input  logic [N_FWD*REG_W-1:0]        FWD_DST,
    input  logic [N_FWD-1:0]              FWD_WE,
    input  logic [N_FWD-1:0]              FWD_RDY,
    input  logic                          MC_START,
    input  logic [REG_W-1:0]              MC_DST,
    input  logic                          MC_DONE,
    input  logic                          FLUSH,
`ifdef HZRD_PERF_CNT_EN
    input  logic                          CNT_CLR,
    output logic [31:0]                   STALL_CNT,
`endif
    output logic [fwd_sel_w(N_FWD)-1:0]   ALU_FWD_A,
    output logic [fwd_sel_w(N_FWD)-1:0]   ALU_FWD_B,
    output logic                          STALL,
    output logic                          MC_BUSY,
    output logic                          MC_ERR
);

    localparam int c_SEL_W = fwd_sel_w(N_FWD);

    logic [2**REG_W-1:0] w_busy_vec;
    logic [c_SEL_W-1:0]  w_sel_a;
    logic [c_SEL_W-1:0]  w_sel_b;
    logic                w_haz_a;
    logic                w_haz_b;
    logic                w_load_use;
    logic                w_sb_haz;
    logic                w_mc_struct;
    logic                w_stall;

    hazard_scoreboard #(
        .REG_W  (REG_W),
        .MC_TMO (MC_TMO)
    ) u_scoreboard (
        .clk        (CLK),
        .rst_n      (RESET_N),
        .i_mc_start (MC_START),
        .i_mc_dst   (MC_DST),
        .i_mc_done  (MC_DONE),
        .i_flush    (FLUSH),
        .o_busy_vec (w_busy_vec),
        .o_mc_busy  (MC_BUSY),
        .o_mc_err   (MC_ERR)
    );

    // Walk from the oldest stage down so the nearest matching stage wins.
    always_comb begin
        w_sel_a = c_SEL_W'(FWD_NONE);
        w_sel_b = c_SEL_W'(FWD_NONE);
        w_haz_a = 1'b0;
        w_haz_b = 1'b0;
        for (int i = N_FWD - 1; i >= 0; i--) begin
            if (FWD_WE[i] && (FWD_DST[i*REG_W +: REG_W] == RS_E) && (RS_E != '0)) begin
                w_sel_a = c_SEL_W'(i + 1);
                w_haz_a = ~FWD_RDY[i];
            end
            if (FWD_WE[i] && (FWD_DST[i*REG_W +: REG_W] == RT_E) && (RT_E != '0)) begin
                w_sel_b = c_SEL_W'(i + 1);
                w_haz_b = ~FWD_RDY[i];
            end
        end
    end

    assign w_load_use  = LOAD_E && (RT_E != '0) && ((RS_D == RT_E) || (RT_D == RT_E));
    assign w_sb_haz    = ((RS_D != '0) && w_busy_vec[RS_D]) || ((RT_D != '0) && w_busy_vec[RT_D]);
    assign w_mc_struct = MC_D && (MC_BUSY || MC_START);
    assign w_stall     = w_haz_a | w_haz_b | w_load_use | w_sb_haz | w_mc_struct;

    assign ALU_FWD_A = w_sel_a;
    assign ALU_FWD_B = w_sel_b;
    assign STALL     = w_stall;

`ifdef HZRD_PERF_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_stall_cnt <= '0;
        end else if (CNT_CLR) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign STALL_CNT = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit_ms.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_unit_ms
// Brief    : Scoreboard-driven self-checking bench for hazard_unit_ms.
// Revision : 1.0
// ============================================================================
module tb_hazard_unit_ms;

    localparam int REG_W = 5;
    localparam int N_FWD = 3;

    logic                   CLK = 1'b0;
    logic                   RESET_N = 1'b0;
    logic [REG_W-1:0]       RS_D, RT_D, RS_E, RT_E, MC_DST;
    logic                   LOAD_E, MC_D, MC_START, MC_DONE, FLUSH;
    logic [N_FWD*REG_W-1:0] FWD_DST;
    logic [N_FWD-1:0]       FWD_WE, FWD_RDY;
    logic [1:0]             ALU_FWD_A, ALU_FWD_B;
    logic                   STALL, MC_BUSY, MC_ERR;
`ifdef HZRD_PERF_CNT_EN
    logic                   CNT_CLR = 1'b0;
    logic [31:0]            STALL_CNT;
`endif

    string       q_name[$];
    logic [31:0] q_exp[$];
    string       e_name;
    logic [31:0] e_exp;
    int          total = 0;
    int          bad = 0;

    hazard_unit_ms dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .RS_D      (RS_D),
        .RT_D      (RT_D),
        .RS_E      (RS_E),
        .RT_E      (RT_E),
        .LOAD_E    (LOAD_E),
        .MC_D      (MC_D),
        .FWD_DST   (FWD_DST),
        .FWD_WE    (FWD_WE),
        .FWD_RDY   (FWD_RDY),
        .MC_START  (MC_START),
        .MC_DST    (MC_DST),
        .MC_DONE   (MC_DONE),
        .FLUSH     (FLUSH),
`ifdef HZRD_PERF_CNT_EN
        .CNT_CLR   (CNT_CLR),
        .STALL_CNT (STALL_CNT),
`endif
        .ALU_FWD_A (ALU_FWD_A),
        .ALU_FWD_B (ALU_FWD_B),
        .STALL     (STALL),
        .MC_BUSY   (MC_BUSY),
        .MC_ERR    (MC_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic clear_inputs();
        RS_D = '0; RT_D = '0; RS_E = '0; RT_E = '0; MC_DST = '0;
        LOAD_E = 0; MC_D = 0; MC_START = 0; MC_DONE = 0; FLUSH = 0;
        FWD_DST = '0; FWD_WE = '0; FWD_RDY = '0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input string n, input logic [31:0] v);
        q_name.push_back(n);
        q_exp.push_back(v);
    endtask

    task automatic pop();
        e_name = q_name.pop_front();
        e_exp  = q_exp.pop_front();
        total++;
    endtask

    // Reference forward search: first (nearest) writing stage that matches.
    function automatic logic [2:0] fwd_ref(input logic [REG_W-1:0] r,
                                           input logic [N_FWD*REG_W-1:0] dst,
                                           input logic [N_FWD-1:0] we,
                                           input logic [N_FWD-1:0] rdy);
        logic [2:0] res = 3'b000;
        logic       hit = 1'b0;
        for (int i = 0; i < N_FWD; i++) begin
            if (!hit && r != 0 && we[i] && dst[i*REG_W +: REG_W] == r) begin
                hit = 1'b1;
                res = {~rdy[i], 2'(i + 1)};
            end
        end
        return res;
    endfunction

    task automatic test_reset();
        clear_inputs();
        RESET_N = 1'b0;
        #2;
        push("rst_busy", 0); push("rst_err", 0); push("rst_stall", 0);
        pop(); if (32'(MC_BUSY) !== e_exp) begin bad++; $display("FAIL %s got=%0h want=%0h", e_name, MC_BUSY, e_exp); end
        pop(); if (32'(MC_ERR) !== e_exp) begin bad++; $display("FAIL %s got=%0h want=%0h", e_name, MC_ERR, e_exp); end
        pop(); if (32'(STALL) !== e_exp) begin bad++; $display("FAIL %s got=%0h want=%0h", e_name, STALL, e_exp); end
        @(negedge CLK);
        RESET_N = 1'b1;
        tick();
    endtask

    task automatic test_forward();
        logic [2:0] ra, rb;
        logic       exp_stall;
        for (int n = 0; n < 28; n++) begin
            clear_inputs();
            case (n)
                0: begin RS_E = 3; FWD_DST = {5'd3, 5'd3, 5'd3}; FWD_WE = 3'b111; FWD_RDY = 3'b111; end
                1: begin RS_E = 3; FWD_DST = {5'd3, 5'd3, 5'd3}; FWD_WE = 3'b110; FWD_RDY = 3'b111; end
                2: begin RS_E = 3; RT_E = 3; FWD_DST = {5'd3, 5'd3, 5'd3}; FWD_WE = 3'b110; FWD_RDY = 3'b101; end
                3: begin RS_E = 0; RT_E = 0; FWD_DST = '0; FWD_WE = 3'b111; FWD_RDY = 3'b111; end
                default: begin
                    RS_E = REG_W'($urandom_range(0, 3));
                    RT_E = REG_W'($urandom_range(0, 3));
                    for (int k = 0; k < N_FWD; k++) FWD_DST[k*REG_W +: REG_W] = REG_W'($urandom_range(0, 3));
                    FWD_WE  = N_FWD'($urandom);
                    FWD_RDY = N_FWD'($urandom);
                end
            endcase
            ra = fwd_ref(RS_E, FWD_DST, FWD_WE, FWD_RDY);
            rb = fwd_ref(RT_E, FWD_DST, FWD_WE, FWD_RDY);
            exp_stall = ra[2] | rb[2];
            push("fwd_stall", 32'(exp_stall));
            if (!exp_stall) begin
                push("fwd_a", 32'(ra[1:0]));
                push("fwd_b", 32'(rb[1:0]));
            end
            #1;
            pop(); if (32'(STALL) !== e_exp) begin bad++; $display("FAIL %s[%0d] got=%0h want=%0h", e_name, n, STALL, e_exp); end
            if (!exp_stall) begin
                pop(); if (32'(ALU_FWD_A) !== e_exp) begin bad++; $display("FAIL %s[%0d] got=%0h want=%0h", e_name, n, ALU_FWD_A, e_exp); end
                pop(); if (32'(ALU_FWD_B) !== e_exp) begin bad++; $display("FAIL %s[%0d] got=%0h want=%0h", e_name, n, ALU_FWD_B, e_exp); end
            end
        end
        clear_inputs();
    endtask

    task automatic test_load_use();
        for (int n = 0; n < 5; n++) begin
            clear_inputs();
            LOAD_E = 1;
            case (n)
                0: begin RT_E = 5; RS_D = 5; push("ld_rs", 1); end
                1: begin RT_E = 0; RS_D = 0; push("ld_r0", 0); end
                2: begin RT_E = 5; RT_D = 5; push("ld_rt", 1); end
                3: begin RT_E = 5; RS_D = 6; RT_D = 4; push("ld_nomatch", 0); end
                default: begin LOAD_E = 0; RT_E = 5; RS_D = 5; push("ld_noload", 0); end
            endcase
            #1;
            pop(); if (32'(STALL) !== e_exp) begin bad++; $display("FAIL %s got=%0h want=%0h", e_name, STALL, e_exp); end
        end
        clear_inputs();
    endtask

    task automatic test_multicycle();
        clear_inputs();
        MC_START = 1; MC_DST = 7; MC_D = 1;
        #1;
        push("mc_struct_start", 1); push("mc_busy_pre", 0);
        pop(); if (32'(STALL) !== e_exp) begin bad++; $display("FAIL %s got=%0h want=%0h", e_name, STALL, e_exp); end
        pop(); if (32'(MC_BUSY) !== e_exp) begin bad++; $display("FAIL %s got=%0h want=%0h", e_name, MC_BUSY, e_exp); end
        tick();
        clear_inputs();
        RT_D = 7;
        #1;
        push("mc_rt_stall", 1); push("mc_busy", 1);
        pop(); if (32'(STALL) !== e_exp) begin bad++; $display("FAIL %s got=%0h want=%0h", e_name, STALL, e_exp); end
        pop(); if (32'(MC_BUSY) !== e_exp) begin bad++; $display("FAIL %s got=%0h want=%0h", e_name, MC_BUSY, e_exp); end
        RT_D = 0; RS_D = 6;
        #1;
        push("mc_other_reg", 0);
        pop(); if (32'(STALL) !== e_exp) begin bad++; $display("FAIL %s got=%0h want=%0h", e_name, STALL, e_exp); end
        RS_D = 0; MC_D = 1;
        #1;
        push("mc_struct_busy", 1);
        pop(); if (32'(STALL) !== e_exp) begin bad++; $display("FAIL %s got=%0h want=%0h", e_name, STALL, e_exp); end
        MC_D = 0; MC_DONE = 1;
        tick();
        MC_DONE = 0; RT_D = 7;
        #1;
        push("mc_done_stall", 0); push("mc_done_busy", 0);
        pop(); if (32'(STALL) !== e_exp) begin bad++; $display("FAIL %s got=%0h want=%0h", e_name, STALL, e_exp); end
        pop(); if (32'(MC_BUSY) !== e_exp) begin bad++; $display("FAIL %s got=%0h want=%0h", e_name, MC_BUSY, e_exp); end
        MC_DONE = 1;
        tick();
        MC_DONE = 0;
        push("mc_done_idle", 0);
        pop(); if (32'(MC_BUSY) !== e_exp) begin bad++; $display("FAIL %s got=%0h want=%0h", e_name, MC_BUSY, e_exp); end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        MC_START = 1; MC_DST = 4;
        tick();
        MC_START = 0; MC_DONE = 1; MC_START = 1; MC_DST = 6;
        tick();
        clear_inputs();
        RS_D = 4;
        #1;
        push("b2b_old_clear", 0);
        pop(); if (32'(STALL) !== e_exp) begin bad++; $display("FAIL %s got=%0h want=%0h", e_name, STALL, e_exp); end
        RS_D = 6;
        #1;
        push("b2b_new_set", 1); push("b2b_busy", 1);
        pop(); if (32'(STALL) !== e_exp) begin bad++; $display("FAIL %s got=%0h want=%0h", e_name, STALL, e_exp); end
        pop(); if (32'(MC_BUSY) !== e_exp) begin bad++; $display("FAIL %s got=%0h want=%0h", e_name, MC_BUSY, e_exp); end
        MC_DONE = 1; MC_START = 1; MC_DST = 6;
        tick();
        MC_DONE = 0; MC_START = 0;
        #1;
        push("b2b_same_reg", 1);
        pop(); if (32'(STALL) !== e_exp) begin bad++; $display("FAIL %s got=%0h want=%0h", e_name, STALL, e_exp); end
        MC_DONE = 1;
        tick();
        MC_DONE = 0;
        push("b2b_drain", 0);
        pop(); if (32'(STALL) !== e_exp) begin bad++; $display("FAIL %s got=%0h want=%0h", e_name, STALL, e_exp); end
        clear_inputs();
    endtask

    task automatic test_flush();
        clear_inputs();
        MC_START = 1; MC_DST = 8; FLUSH = 1;
        tick();
        clear_inputs();
        RS_D = 8;
        #1;
        push("flush_stall", 0); push("flush_busy", 0);
        pop(); if (32'(STALL) !== e_exp) begin bad++; $display("FAIL %s got=%0h want=%0h", e_name, STALL, e_exp); end
        pop(); if (32'(MC_BUSY) !== e_exp) begin bad++; $display("FAIL %s got=%0h want=%0h", e_name, MC_BUSY, e_exp); end
        MC_START = 1; MC_DST = 8;
        tick();
        MC_START = 0; FLUSH = 1;
        tick();
        FLUSH = 0;
        #1;
        push("flush_keeps_bit", 1);
        pop(); if (32'(STALL) !== e_exp) begin bad++; $display("FAIL %s got=%0h want=%0h", e_name, STALL, e_exp); end
        MC_DONE = 1;
        tick();
        clear_inputs();
    endtask

    task automatic test_timeout();
        clear_inputs();
        MC_START = 1; MC_DST = 10;
        tick();
        clear_inputs();
        repeat (63) tick();
        push("tmo_early", 0);
        pop(); if (32'(MC_ERR) !== e_exp) begin bad++; $display("FAIL %s got=%0h want=%0h", e_name, MC_ERR, e_exp); end
        tick();
        push("tmo_hit", 1);
        pop(); if (32'(MC_ERR) !== e_exp) begin bad++; $display("FAIL %s got=%0h want=%0h", e_name, MC_ERR, e_exp); end
        MC_DONE = 1;
        tick();
        MC_DONE = 0;
        push("tmo_sticky", 1); push("tmo_busy_off", 0);
        pop(); if (32'(MC_ERR) !== e_exp) begin bad++; $display("FAIL %s got=%0h want=%0h", e_name, MC_ERR, e_exp); end
        pop(); if (32'(MC_BUSY) !== e_exp) begin bad++; $display("FAIL %s got=%0h want=%0h", e_name, MC_BUSY, e_exp); end
        @(negedge CLK);
        #2 RESET_N = 1'b0;
        #1;
        push("tmo_async_clr", 0);
        pop(); if (32'(MC_ERR) !== e_exp) begin bad++; $display("FAIL %s got=%0h want=%0h", e_name, MC_ERR, e_exp); end
        @(negedge CLK);
        RESET_N = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_op();
        clear_inputs();
        MC_START = 1; MC_DST = 11;
        tick();
        clear_inputs();
        RS_D = 11;
        #2 RESET_N = 1'b0;
        #1;
        push("rmo_busy", 0); push("rmo_stall", 0);
        pop(); if (32'(MC_BUSY) !== e_exp) begin bad++; $display("FAIL %s got=%0h want=%0h", e_name, MC_BUSY, e_exp); end
        pop(); if (32'(STALL) !== e_exp) begin bad++; $display("FAIL %s got=%0h want=%0h", e_name, STALL, e_exp); end
        @(negedge CLK);
        RESET_N = 1'b1;
        MC_DONE = 1;
        tick();
        MC_DONE = 0;
        push("rmo_late_done", 0);
        pop(); if (32'(MC_BUSY) !== e_exp) begin bad++; $display("FAIL %s got=%0h want=%0h", e_name, MC_BUSY, e_exp); end
        clear_inputs();
    endtask

`ifdef HZRD_PERF_CNT_EN
    task automatic test_perf_cnt();
        clear_inputs();
        CNT_CLR = 1;
        tick();
        CNT_CLR = 0;
        push("cnt_clr", 0);
        pop(); if (STALL_CNT !== e_exp) begin bad++; $display("FAIL %s got=%0h want=%0h", e_name, STALL_CNT, e_exp); end
        LOAD_E = 1; RT_E = 5; RS_D = 5;
        repeat (10) tick();
        clear_inputs();
        tick();
        push("cnt_ten", 10);
        pop(); if (STALL_CNT !== e_exp) begin bad++; $display("FAIL %s got=%0h want=%0h", e_name, STALL_CNT, e_exp); end
        LOAD_E = 1; RT_E = 5; RS_D = 5; CNT_CLR = 1;
        tick();
        CNT_CLR = 0;
        push("cnt_clr_wins", 0);
        pop(); if (STALL_CNT !== e_exp) begin bad++; $display("FAIL %s got=%0h want=%0h", e_name, STALL_CNT, e_exp); end
        tick();
        push("cnt_resume", 1);
        pop(); if (STALL_CNT !== e_exp) begin bad++; $display("FAIL %s got=%0h want=%0h", e_name, STALL_CNT, e_exp); end
        clear_inputs();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_multicycle();
        test_back_to_back();
        test_flush();
        test_timeout();
        test_reset_mid_op();
`ifdef HZRD_PERF_CNT_EN
        test_perf_cnt();
`endif
        if (q_exp.size() != 0) begin
            bad++;
            total++;
            $display("FAIL queue_drain: leftover=%0d want=0", q_exp.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_unit_ms.md
HAZARD_UNIT_MS -- requirements
Module: hazard_unit_ms

Interface
REQ-001 SHALL have parameter REG_W, default 5, meaning register-index width.
REQ-002 SHALL have parameter N_FWD, default 3, meaning number of forwarding stages after E (index 0 = M1, N_FWD-1 = WB).
REQ-003 SHALL have parameter MC_TMO, default 64, meaning multicycle-unit timeout in cycles.
REQ-004 SHALL have ports, one per line:
- CLK  in  1  clock; the block has one clock.
- RESET_N  in  1  reset, asynchronous and active-low.
- RS_D, RT_D  in  REG_W  source registers in D.
- RS_E, RT_E  in  REG_W  source registers in E.
- LOAD_E  in  1  E holds a load writing RT_E.
- MC_D  in  1  D holds a multicycle op (mul/div).
- FWD_DST  in  N_FWD*REG_W  destination register per stage.
- FWD_WE  in  N_FWD  stage writes the register file.
- FWD_RDY  in  N_FWD  stage result is valid for forwarding.
- MC_START  in  1  multicycle op leaves E.
- MC_DST  in  REG_W  its destination.
- MC_DONE  in  1  multicycle unit writes back this cycle.
- FLUSH  in  1  E squashed.
- CNT_CLR  in  1  clears stall counter.
- ALU_FWD_A, ALU_FWD_B  out  $clog2(N_FWD+1)  forward select.
- STALL  out  1  freeze D/E, bubble into M1.
- MC_BUSY  out  1  multicycle op outstanding.
- MC_ERR  out  1  sticky timeout.
- STALL_CNT  out  32  stall-cycle count (macro only).

Function
REQ-005 ALU_FWD_A SHALL be 1+i for lowest i with FWD_WE[i], FWD_DST[i]==RS_E, RS_E!=0; else 0. ALU_FWD_B is the same using RT_E.
REQ-006 If the selected stage has FWD_RDY[i]=0, STALL SHALL assert (E-stage data hazard); the forward select value that cycle is don't-care.
REQ-007 STALL SHALL assert when LOAD_E and RT_E!=0 and (RS_D==RT_E or RT_D==RT_E).
REQ-008 STALL SHALL assert when RS_D or RT_D is nonzero and marked busy in the scoreboard.
REQ-009 STALL SHALL assert when MC_D and (MC_BUSY or MC_START), giving a structural hazard with one outstanding op.
REQ-010 STALL SHALL be the OR of REQ-006..009 and SHALL be purely combinational, with zero latency.
REQ-011 The scoreboard SHALL be a 2**REG_W busy vector; at the rising edge, MC_START & ~FLUSH & MC_DST!=0 sets busy[MC_DST]; MC_DONE clears the bit of the outstanding op.
REQ-012 For simultaneous MC_DONE and MC_START, the old bit SHALL clear and the new bit set; if both name the same register, the bit SHALL end up set.
REQ-013 Register 0 SHALL never be busy or forwarded.
REQ-014 MC_BUSY SHALL be 1 from the cycle after an accepted MC_START until the cycle after MC_DONE.
REQ-015 A timeout counter SHALL count cycles while MC_BUSY, reset on MC_DONE; reaching MC_TMO sets MC_ERR sticky until reset.
REQ-016 MC_DONE with MC_BUSY=0 SHALL be ignored.
REQ-017 FLUSH SHALL NOT clear existing busy bits, because an issued op commits.

Reset
REQ-018 While RESET_N=0: busy vector, MC_BUSY, MC_ERR, timeout counter and STALL_CNT SHALL be 0 immediately, regardless of CLK.
REQ-019 Reset mid-operation SHALL discard the outstanding op; a later MC_DONE is ignored per REQ-016.

Configuration
REQ-020 Macro HZRD_PERF_CNT_EN defined: STALL_CNT increments each cycle STALL=1, saturates at 0xFFFFFFFF, and zeroes on CNT_CLR (CNT_CLR wins over increment).
REQ-021 Macro undefined: STALL_CNT and CNT_CLR ports SHALL be absent and no counter logic exists.

Structure
REQ-022 Package hazard_pkg SHALL hold the forward-select width function, the FWD_NONE=0 constant and the default REG_W/N_FWD.
REQ-023 Sub-module hazard_scoreboard SHALL hold the busy vector, MC_BUSY and timeout logic.

Verification
REQ-024 RS_E=3, FWD_DST={M1:3,M2:3,WB:3}, all WE/RDY=1 -> ALU_FWD_A=1 (nearest wins).
REQ-025 LOAD_E=1, RT_E=5, RS_D=5 -> STALL=1; same with RT_E=0 -> STALL=0.
REQ-026 MC_START, MC_DST=7; next cycle RT_D=7 -> STALL=1, MC_BUSY=1; MC_DONE -> STALL=0 the following cycle.
REQ-027 MC_START with FLUSH=1 -> busy[MC_DST] stays 0 and MC_BUSY=0.
REQ-028 MC_START, then no MC_DONE for 64 cycles -> MC_ERR=1 and stays 1 after MC_DONE; RESET_N pulse -> all 0.
REQ-029 With HZRD_PERF_CNT_EN, 10 stall cycles -> STALL_CNT=10; CNT_CLR concurrent with a stall -> STALL_CNT=0.
